// File: rtl/sha256_feeder.sv
// SHA-256 message padder/sequencer: fills 512-bit blocks from a byte stream and runs them through a hash core.
// One byte per cycle in, s_ready low from the final byte until the block is hashed; SHA256_FEEDER_TRACE_EN enables $display tracing.
module sha256_feeder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic         blk_start,
    output logic [511:0] blk_data,
    output logic         blk_use_init,
    output logic [255:0] blk_hash_init,
    input  logic [255:0] core_hash,
    input  logic         core_ready,
    output logic [255:0] digest,
    output logic         digest_valid
);
    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, ACK, WAIT, GAP} state_t;

    state_t         state_q, state_d;
    logic [511:0]   buf_q, buf_d;
    logic [6:0]     idx_q, idx_d;
    logic [63:0]    len_q, len_d;
    logic           use_init_q, use_init_d;
    logic [255:0]   chain_q, chain_d;
    logic [255:0]   digest_q, digest_d;
    logic           digest_valid_q, digest_valid_d;
    logic           extra_q, extra_d;
    logic           need80_q, need80_d;
    logic           len_done_q, len_done_d;
    logic           s_ready_c;
    logic [6:0]     idx_inc;

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        idx_d          = idx_q;
        len_d          = len_q;
        use_init_d     = use_init_q;
        chain_d        = chain_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        extra_d        = extra_q;
        need80_d       = need80_q;
        len_done_d     = len_done_q;
        s_ready_c      = 1'b0;
        blk_start      = 1'b0;
        idx_inc        = idx_q + 7'd1;
        unique case (state_q)
            IDLE, FILL: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    buf_d[{~idx_q[5:0], 3'b000} +: 8] = s_data;
                    idx_d   = idx_inc;
                    len_d   = len_q + 64'd8;
                    state_d = FILL;
                    if (s_last) begin
                        // A message ending exactly on a block boundary carries its 0x80 into the next block.
                        if (idx_inc[6]) begin
                            need80_d = 1'b1;
                            state_d  = ISSUE;
                        end else begin
                            buf_d[{~idx_inc[5:0], 3'b000} +: 8] = 8'h80;
                            idx_d   = idx_inc + 7'd1;
                            state_d = PAD;
                        end
                    end else if (idx_inc[6]) begin
                        state_d = ISSUE;
                    end
                end
            end
            PAD: begin
                if (idx_q == 7'd56) begin
                    state_d = LEN;
                end else if (idx_q[6]) begin
                    extra_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    buf_d[{~idx_q[5:0], 3'b000} +: 8] = 8'h00;
                    idx_d = idx_inc;
                end
            end
            LEN: begin
                buf_d[63:0] = len_q;
                len_done_d  = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                blk_start = 1'b1;
                state_d   = ACK;
            end
            ACK: state_d = WAIT;
            WAIT: begin
                if (core_ready) begin
                    chain_d    = core_hash;
                    use_init_d = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (extra_q) begin
                    buf_d      = {448'd0, len_q};
                    extra_d    = 1'b0;
                    len_done_d = 1'b1;
                    state_d    = ISSUE;
                end else if (!len_done_q) begin
                    buf_d   = '0;
                    idx_d   = 7'd0;
                    state_d = FILL;
                    if (need80_q) begin
                        buf_d[511:504] = 8'h80;
                        idx_d          = 7'd1;
                        need80_d       = 1'b0;
                        state_d        = PAD;
                    end
                end else begin
                    digest_d       = chain_q;
                    digest_valid_d = 1'b1;
                    buf_d          = '0;
                    idx_d          = 7'd0;
                    len_d          = 64'd0;
                    use_init_d     = 1'b0;
                    len_done_d     = 1'b0;
                    state_d        = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            idx_q          <= '0;
            len_q          <= '0;
            use_init_q     <= 1'b0;
            chain_q        <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            extra_q        <= 1'b0;
            need80_q       <= 1'b0;
            len_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            use_init_q     <= use_init_d;
            chain_q        <= chain_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            extra_q        <= extra_d;
            need80_q       <= need80_d;
            len_done_q     <= len_done_d;
        end
    end

    assign s_ready       = s_ready_c & rst_n;
    assign blk_data      = buf_q;
    assign blk_use_init  = use_init_q;
    assign blk_hash_init = chain_q;
    assign digest        = digest_q;
    assign digest_valid  = digest_valid_q;

`ifdef SHA256_FEEDER_TRACE_EN
    logic [31:0] trace_blk_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_blk_q <= '0;
        end else begin
            if (state_q != state_d)
                $display("sha256_feeder: %s -> %s", state_q.name(), state_d.name());
            if (state_q == ISSUE) begin
                $display("sha256_feeder: block %0d use_init=%0b data=%h", trace_blk_q, use_init_q, buf_q);
                trace_blk_q <= trace_blk_q + 32'd1;
            end
            if (digest_valid_d)
                $display("sha256_feeder: digest %h", digest_d);
        end
    end
`else
    // Untraced build: identical cycle behaviour, no simulation output.
`endif
endmodule

// File: tb/tb_sha256_feeder.sv
module tb_sha256_feeder;
    typedef logic [7:0]   bq_t[$];
    typedef logic [511:0] blkq_t[$];
    typedef struct { logic [511:0] d; logic ui; logic [255:0] hi; } rec_t;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] KAT_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] KAT_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_valid, s_last, s_ready;
    logic         blk_start, blk_use_init;
    logic [511:0] blk_data;
    logic [255:0] blk_hash_init, core_hash, digest;
    logic         core_ready, digest_valid;

    sha256_feeder dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .blk_start(blk_start), .blk_data(blk_data), .blk_use_init(blk_use_init), .blk_hash_init(blk_hash_init),
        .core_hash(core_hash), .core_ready(core_ready), .digest(digest), .digest_valid(digest_valid));

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    rec_t         recs[$];
    logic [255:0] digs[$];
    int           stale_cfg = 0;
    int           delay_cfg = 1;
    int           unstable = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Reference padding: append 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit length.
    function automatic void pad_msg(input bq_t m, output blkq_t blks);
        bq_t          q;
        logic [63:0]  bits;
        logic [511:0] b;
        q = m;
        bits = 64'(m.size()) * 64'd8;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
        blks = {};
        for (int k = 0; k < q.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = q[64*k + j];
            blks.push_back(b);
        end
    endfunction

    function automatic void str2q(input string s, output bq_t m);
        m = {};
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    endfunction

    function automatic void rand_msg(input int n, output bq_t m);
        m = {};
        for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(255, 0)));
    endfunction

    function automatic logic [255:0] dig_at(input int i);
        if (i < digs.size()) return digs[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hash core stand-in: optional stale ready/hash after a start, then a programmable latency.
    initial begin : core_model
        rec_t         r;
        logic [255:0] pend;
        logic         busy;
        int           sl, dl;
        busy = 1'b0; sl = 0; dl = 0; pend = '0;
        core_ready = 1'b0; core_hash = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                busy = 1'b0; core_ready = 1'b0;
            end else if (blk_start === 1'b1) begin
                r.d = blk_data; r.ui = blk_use_init; r.hi = blk_hash_init;
                recs.push_back(r);
                pend = compress(blk_use_init ? blk_hash_init : IV, blk_data);
                busy = 1'b1; sl = stale_cfg; dl = delay_cfg;
                if (sl == 0) core_ready = 1'b0;
            end else if (busy) begin
                if (blk_data !== r.d || blk_use_init !== r.ui || blk_hash_init !== r.hi || s_ready !== 1'b0)
                    unstable++;
                if (sl > 0) begin
                    sl--;
                    if (sl == 0) core_ready = 1'b0;
                end else begin
                    if (dl > 0) dl--;
                    if (dl == 0) begin core_ready = 1'b1; core_hash = pend; busy = 1'b0; end
                end
            end
        end
    end

    initial begin : digest_mon
        forever begin
            @(posedge clk); #1;
            if (digest_valid === 1'b1) digs.push_back(digest);
        end
    end

    task automatic send_msg(input bq_t m, input int gap_max);
        int n;
        for (int i = 0; i < m.size(); i++) begin
            s_valid = 1'b1; s_data = m[i]; s_last = (i == m.size() - 1);
            for (int t = 0; t < 5000 && s_ready !== 1'b1; t++) begin @(posedge clk); #1; end
            @(posedge clk); #1;
            if (gap_max > 0 && i != m.size() - 1) begin
                s_valid = 1'b0;
                n = $urandom_range(gap_max, 0);
                repeat (n) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_digs(input string tag, input int target);
        for (int t = 0; t < 4000 && digs.size() < target; t++) begin @(posedge clk); #1; end
        chk({tag, "_digest_count"}, digs.size(), target);
    endtask

    task automatic check_msg(input string tag, input bq_t m, input int rb, input int di, output int nb);
        blkq_t        blks;
        logic [255:0] chain;
        pad_msg(m, blks);
        nb = blks.size();
        chain = IV;
        for (int k = 0; k < blks.size(); k++) begin
            if (rb + k < recs.size()) begin
                chk({tag, "_blk"}, recs[rb+k].d, blks[k]);
                chk({tag, "_use_init"}, recs[rb+k].ui, k != 0);
                if (k != 0) chk({tag, "_hash_init"}, recs[rb+k].hi, chain);
            end
            chain = compress(chain, blks[k]);
        end
        chk({tag, "_digest"}, dig_at(di), chain);
    endtask

    task automatic run_msg(input string tag, input bq_t m, input int gap_max, output int rb);
        int db, nb;
        rb = recs.size(); db = digs.size();
        send_msg(m, gap_max);
        s_valid = 1'b0; s_last = 1'b0;
        wait_digs(tag, db + 1);
        check_msg(tag, m, rb, db, nb);
        chk({tag, "_nblk"}, recs.size() - rb, nb);
    endtask

    initial begin : main
        bq_t          m;
        int           rb, db, nb, nb2, u0;
        logic [511:0] exp_blk;
        int           lens [6] = '{1, 56, 57, 63, 119, 120};
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_blk_start", blk_start, 1'b0);
        chk("rst_use_init", blk_use_init, 1'b0);
        chk("rst_digest_valid", digest_valid, 1'b0);
        chk("rst_blk_data", blk_data, '0);
        chk("rst_hash_init", blk_hash_init, '0);
        chk("rst_digest", digest, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", s_ready, 1'b1);

        str2q("abc", m);
        run_msg("abc", m, 0, rb);
        chk("abc_kat", dig_at(digs.size() - 1), KAT_ABC);
        chk("abc_len_field", recs[rb].d[63:0], 64'h18);

        str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m);
        run_msg("m56", m, 1, rb);
        chk("m56_kat", dig_at(digs.size() - 1), KAT_56);

        rand_msg(55, m);
        run_msg("m55", m, 2, rb);
        chk("m55_len_field", recs[rb].d[63:0], 64'h1B8);
        chk("m55_pad80", recs[rb].d[71:64], 8'h80);

        rand_msg(64, m);
        run_msg("m64", m, 0, rb);
        exp_blk = {8'h80, 440'd0, 64'h200};
        chk("m64_second_block", recs[rb+1].d, exp_blk);

        // Two "abc" messages with s_valid held across the boundary.
        str2q("abc", m);
        rb = recs.size(); db = digs.size();
        send_msg(m, 0);
        send_msg(m, 0);
        s_valid = 1'b0; s_last = 1'b0;
        wait_digs("b2b", db + 2);
        check_msg("b2b_first", m, rb, db, nb);
        check_msg("b2b_second", m, rb + nb, db + 1, nb2);
        chk("b2b_nblk", recs.size() - rb, nb + nb2);
        chk("b2b_kat1", dig_at(db), KAT_ABC);
        chk("b2b_kat2", dig_at(db + 1), KAT_ABC);

        // Stale done level through ACK, then a 100-cycle core stall.
        stale_cfg = 2; delay_cfg = 100; u0 = unstable;
        rand_msg(20, m);
        run_msg("stall", m, 1, rb);
        chk("stall_stable", unstable, u0);
        stale_cfg = 0;

        foreach (lens[i]) begin
            delay_cfg = $urandom_range(6, 1);
            rand_msg(lens[i], m);
            run_msg($sformatf("len%0d", lens[i]), m, 2, rb);
        end
        for (int i = 0; i < 4; i++) begin
            delay_cfg = $urandom_range(8, 1);
            rand_msg($urandom_range(130, 1), m);
            run_msg($sformatf("rnd%0d", i), m, 3, rb);
        end

        // Reset while the first block of a two-block message waits on the core.
        delay_cfg = 60;
        rand_msg(60, m);
        rb = recs.size(); db = digs.size();
        send_msg(m, 0);
        s_valid = 1'b0; s_last = 1'b0;
        for (int t = 0; t < 2000 && recs.size() <= rb; t++) begin @(posedge clk); #1; end
        chk("abort_block_issued", recs.size(), rb + 1);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("abort_s_ready", s_ready, 1'b0);
        chk("abort_blk_start", blk_start, 1'b0);
        chk("abort_use_init", blk_use_init, 1'b0);
        chk("abort_digest_valid", digest_valid, 1'b0);
        chk("abort_blk_data", blk_data, '0);
        chk("abort_hash_init", blk_hash_init, '0);
        chk("abort_digest", digest, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk); #1;
        chk("abort_no_digest", digs.size(), db);
        delay_cfg = 1;
        str2q("abc", m);
        run_msg("post_abort", m, 0, rb);
        chk("post_abort_kat", dig_at(digs.size() - 1), KAT_ABC);

        chk("overall_stability", unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sha256_feeder.md
SHA256_FEEDER -- requirements
Module: sha256_feeder

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  async active-low reset
- s_data  in  8  message byte
- s_valid  in  1  byte valid
- s_last  in  1  byte is final byte of message
- s_ready  out  1  feeder accepts byte (transfer = s_valid & s_ready)
- blk_start  out  1  start pulse to hash core
- blk_data  out  512  padded block, byte 0 at [511:504]
- blk_use_init  out  1  0 for first block of message, 1 for later blocks
- blk_hash_init  out  256  chaining value, the previous block's digest
- core_hash  in  256  digest from hash core
- core_ready  in  1  hash core done flag; level, held until the next start is accepted
- digest  out  256  final message digest
- digest_valid  out  1  one-cycle pulse, digest valid

Function
REQ-003 States SHALL be IDLE, FILL, PAD, LEN, ISSUE, ACK, WAIT, GAP.
REQ-004 IDLE/FILL: s_ready=1; each transfer writes s_data to byte index idx (0..63) of the block buffer, increments idx and the 64-bit bit-length counter by 8; IDLE->FILL on the first transfer.
REQ-005 Reaching idx=64 without s_last: s_ready=0; go to ISSUE with the full block.
REQ-006 Transfer with s_last at resulting index n: the next byte (index n) SHALL be written as 0x80; go to PAD.
REQ-007 PAD: write 0x00 one byte per cycle; if 0x80 landed at index <=55, zero-fill to index 55 then go to LEN; otherwise zero-fill to 63, go to ISSUE, mark an extra block pending; that extra block is all-zero bytes 0..55 plus LEN.
REQ-008 LEN: bytes 56..63 SHALL be the big-endian 64-bit message bit length (mod 2^64), in one cycle; go to ISSUE.
REQ-009 ISSUE: blk_start=1 for exactly one cycle, with blk_data, blk_use_init, blk_hash_init stable from this cycle until WAIT exits; go to ACK.
REQ-010 ACK: one cycle with core_ready ignored (the previous done level is stale); go to WAIT.
REQ-011 WAIT: on core_ready=1 capture core_hash into the chaining register; go to GAP.
REQ-012 GAP: blk_start=0 for at least one cycle; then the next action:
- padded block pending -> ISSUE
- LEN not yet written -> FILL/PAD
- message done -> digest<=chaining value, digest_valid=1 one cycle, clear length/idx/use_init, go to IDLE
REQ-013 blk_use_init SHALL be 0 for the first block of each message and 1 for every subsequent block.
REQ-014 s_ready SHALL be 0 in PAD, LEN, ISSUE, ACK, WAIT, GAP.
REQ-015 Minimum message length is 1 byte; s_valid while s_ready=0 SHALL be held by the source, with no loss.
REQ-016 Byte buffer SHALL be cleared to zero on entering FILL for each new block.

Reset
REQ-017 rst_n low SHALL immediately force:
- state=IDLE
- s_ready=0 during reset, 1 after release
- blk_start=0, blk_use_init=0
- digest_valid=0
- blk_data, blk_hash_init, digest, idx and length counter = 0
REQ-018 Reset mid-message SHALL discard the message; no digest_valid is produced for it.

Configuration
REQ-019 Macro SHA256_FEEDER_TRACE_EN defined: $display on every state transition, every ISSUE (block index, use_init, blk_data) and every digest.
REQ-020 Macro SHA256_FEEDER_TRACE_EN undefined: no $display statements; cycle behaviour identical.

Verification
REQ-021 "abc" (3 bytes, s_last on 'c') -> one block 61626380 00..00 00000000_00000018; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-022 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two blocks, use_init 0 then 1; digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-023 55-byte message -> exactly one block, length field 0x1B8; 64-byte message -> two blocks, second block = 0x80, zeros, length 0x200.
REQ-024 Two back-to-back "abc" messages, s_valid held high -> two identical digest_valid pulses; second message's first block has blk_use_init=0.
REQ-025 core_ready held 1 through ACK -> no early capture; core_ready delayed 100 cycles in WAIT -> blk_data stable throughout, s_ready=0.
REQ-026 rst_n low in WAIT of a 2-block message -> all outputs zero; after release, "abc" -> correct digest.
